// File: rtl/rr_packet_mux_pkg.sv
// rtl/rr_packet_mux_pkg.sv - shared types and helpers for the round-robin packet mux
package rr_packet_mux_pkg;

  localparam int unsigned DEF_N_REQ  = 4;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_SRC_W  = $clog2(DEF_N_REQ);

  // IDLE: arbitrate per beat; LOCKED: a multi-beat packet owns the mux
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // One beat as it travels through the skid slice (default widths)
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic                  last;
    logic [DEF_SRC_W-1:0]  src;
  } beat_t;

  // Index of the set bit of a one-hot vector (OR of indices; 0 for all-zero)
  function automatic int unsigned onehot_to_idx(input logic [31:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (onehot[i]) begin
        idx = idx | unsigned'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with mask advanced on an external trigger
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         trigger_i,
  output logic [N-1:0] grant_o
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] mask_q;
  logic [N-1:0] masked;
  logic [N-1:0] pick;

  // Prefer requesters above the last winner; fall back to lowest index overall
  always_comb begin
    masked  = req_i & mask_q;
    pick    = (|masked) ? masked : req_i;
    grant_o = pick & (~pick + ONE);
  end

  // Mask keeps only the bits strictly above the current grant once a trigger fires
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask_q <= '0;
    end else if (trigger_i) begin
      mask_q <= ~(grant_o | (grant_o - ONE));
    end
  end

endmodule

// File: rtl/rr_packet_mux_skid.sv
// rtl/rr_packet_mux_skid.sv - 2-entry valid/ready register slice carrying a beat
module pkt_skid_slice
  import rr_packet_mux_pkg::*;
#(
  parameter type beat_t_p = rr_packet_mux_pkg::beat_t
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    in_valid_i,
  output logic    in_ready_o,
  input  beat_t_p in_beat_i,
  output logic    out_valid_o,
  input  logic    out_ready_i,
  output beat_t_p out_beat_o
);

  beat_t_p    head_q, head_d;
  beat_t_p    tail_q, tail_d;
  logic [1:0] count_q, count_d;
  logic       enq;
  logic       deq;

  // Readiness and output come straight from registers, so no ready path crosses the slice
  assign in_ready_o  = (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign out_beat_o  = head_q;
  assign enq         = in_valid_i & in_ready_o;
  assign deq         = out_valid_o & out_ready_i;

  // Head is always the oldest entry; tail only holds data when two beats are queued
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (enq) begin
          head_d  = in_beat_i;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (enq && deq) begin
          head_d = in_beat_i;
        end else if (enq) begin
          tail_d  = in_beat_i;
          count_d = 2'd2;
        end else if (deq) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        if (deq) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
      default: begin
        count_d = 2'd0;
      end
    endcase
  end

  // Slice storage; flushed asynchronously together with the mux state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rr_packet_mux.sv
// rtl/rr_packet_mux.sv - round-robin packet-boundary mux of N_REQ streams into one
module rr_packet_mux
  import rr_packet_mux_pkg::*;
#(
  parameter int unsigned N_REQ  = DEF_N_REQ,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              in_valid,
  output logic [N_REQ-1:0]              in_ready,
  input  logic [N_REQ-1:0][DATA_W-1:0]  in_data,
  input  logic [N_REQ-1:0]              in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_last,
  output logic [$clog2(N_REQ)-1:0]      out_src,
  output logic                          locked
);

  localparam int unsigned SRC_W = $clog2(N_REQ);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [SRC_W-1:0]  src;
  } mux_beat_t;

  state_e           state_q;
  logic [SRC_W-1:0] src_q;
  logic             locked_q;

  logic [N_REQ-1:0] src_oh;
  logic [N_REQ-1:0] arb_req;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] sel;
  logic [SRC_W-1:0] sel_idx;
  logic             can_accept;
  logic             accept;
  logic             done;
  mux_beat_t        beat_in;
  mux_beat_t        beat_out;

  // One-hot form of the locked owner
  always_comb begin
    src_oh        = '0;
    src_oh[src_q] = 1'b1;
  end

  // While locked only the owner may request, so the completing beat advances
  // the mask past the owner regardless of what other sources are doing
  always_comb begin
    arb_req = (state_q == ST_LOCKED) ? (in_valid & src_oh) : in_valid;
  end

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .clk_i     (clock),
    .rst_i     (~reset),
    .req_i     (arb_req),
    .trigger_i (done),
    .grant_o   (grant)
  );

  // Selection, handshake and the beat presented to the slice
  always_comb begin
    sel      = (state_q == ST_LOCKED) ? src_oh : grant;
    sel_idx  = (state_q == ST_LOCKED) ? src_q : SRC_W'(onehot_to_idx(32'(grant)));
    in_ready = reset ? (sel & {N_REQ{can_accept}}) : '0;
    accept   = |(in_valid & in_ready);
    done     = accept & in_last[sel_idx];
    beat_in      = '0;
    beat_in.data = in_data[sel_idx];
    beat_in.last = in_last[sel_idx];
    beat_in.src  = sel_idx;
  end

  pkt_skid_slice #(
    .beat_t_p (mux_beat_t)
  ) u_slice (
    .clk_i       (clock),
    .rst_ni      (reset),
    .in_valid_i  (accept),
    .in_ready_o  (can_accept),
    .in_beat_i   (beat_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_beat_o  (beat_out)
  );

  assign out_data = beat_out.data;
  assign out_last = beat_out.last;
  assign out_src  = beat_out.src;
  assign locked   = locked_q;

  // Packet-lock FSM: a non-last accepted beat locks to its source until its last beat
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      src_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && !in_last[sel_idx]) begin
            state_q  <= ST_LOCKED;
            src_q    <= sel_idx;
            locked_q <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (done) begin
            state_q  <= ST_IDLE;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_packet_mux.sv
// tb/tb_rr_packet_mux.sv - directed and randomized checks for rr_packet_mux
module tb_rr_packet_mux;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 32;

  logic                         clock = 1'b0;
  logic                         reset = 1'b0;
  logic [N_REQ-1:0]             in_valid = '0;
  logic [N_REQ-1:0]             in_ready;
  logic [N_REQ-1:0][DATA_W-1:0] in_data = '0;
  logic [N_REQ-1:0]             in_last = '0;
  logic                         out_valid;
  logic                         out_ready = 1'b1;
  logic [DATA_W-1:0]            out_data;
  logic                         out_last;
  logic [1:0]                   out_src;
  logic                         locked;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  rr_packet_mux #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .locked    (locked)
  );

  task automatic nedge();
    @(negedge clock);
  endtask

  task automatic pedge();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < N_REQ; i++) in_data[i] = 32'hA0 + i;
    repeat (2) @(posedge clock);
    nedge();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
    n_checks++; if ({out_data, out_last, out_src} !== 35'd0) begin n_fail++; $display("FAIL reset_out_fields: got %h/%b/%0d want 0", out_data, out_last, out_src); end
  endtask

  task automatic test_round_robin();
    @(posedge clock);
    #1;
    reset = 1'b1;
    nedge();
    n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL rr_first_grant: got %b want 0001", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_first_latency: got %b want 0", out_valid); end
    for (int k = 0; k < 8; k++) begin
      logic [3:0] exp_rdy;
      pedge();
      nedge();
      exp_rdy = 4'b0001 << ((k + 1) % 4);
      n_checks++;
      if (out_valid !== 1'b1 || out_src !== 2'(k % 4) || out_data !== 32'(32'hA0 + k % 4)) begin
        n_fail++; $display("FAIL rr_beat[%0d]: got v=%b src=%0d data=%h want v=1 src=%0d data=%h", k, out_valid, out_src, out_data, k % 4, 32'hA0 + k % 4);
      end
      n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", k, in_ready, exp_rdy); end
    end
    in_valid = '0;
    repeat (3) pedge();
  endtask

  task automatic test_lock();
    do_reset();
    in_valid = 4'b0101; in_data[0] = 32'hB0; in_data[2] = 32'hC0; in_last[2] = 1'b1;
    nedge();
    n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL lock_ready0: got %b want 0001", in_ready); end
    pedge(); in_data[0] = 32'hB1;
    nedge();
    n_checks++; if (in_ready !== 4'b0001 || locked !== 1'b1) begin n_fail++; $display("FAIL lock_beat1: got rdy=%b locked=%b want 0001/1", in_ready, locked); end
    n_checks++; if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 32'hB0) begin n_fail++; $display("FAIL lock_out0: got src=%0d data=%h want 0/b0", out_src, out_data); end
    pedge(); in_data[0] = 32'hB2; in_last[0] = 1'b1;
    nedge();
    n_checks++; if (in_ready !== 4'b0001 || locked !== 1'b1) begin n_fail++; $display("FAIL lock_beat2: got rdy=%b locked=%b want 0001/1", in_ready, locked); end
    n_checks++; if (out_src !== 2'd0 || out_data !== 32'hB1) begin n_fail++; $display("FAIL lock_out1: got src=%0d data=%h want 0/b1", out_src, out_data); end
    pedge(); in_valid = 4'b0100;
    nedge();
    n_checks++; if (locked !== 1'b0 || in_ready !== 4'b0100) begin n_fail++; $display("FAIL lock_release: got locked=%b rdy=%b want 0/0100", locked, in_ready); end
    n_checks++; if (out_src !== 2'd0 || out_data !== 32'hB2 || out_last !== 1'b1) begin n_fail++; $display("FAIL lock_out2: got src=%0d data=%h last=%b want 0/b2/1", out_src, out_data, out_last); end
    pedge(); in_valid = '0;
    nedge();
    n_checks++; if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== 32'hC0) begin n_fail++; $display("FAIL lock_next_src: got v=%b src=%0d data=%h want 1/2/c0", out_valid, out_src, out_data); end
    repeat (2) pedge();
  endtask

  task automatic test_stall_lock();
    do_reset();
    in_valid = 4'b1010; in_data[1] = 32'hD0; in_data[3] = 32'hE0; in_last[3] = 1'b1;
    nedge();
    n_checks++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL stall_grant: got %b want 0010", in_ready); end
    pedge(); in_valid = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      nedge();
      n_checks++; if (in_ready !== 4'b0010 || locked !== 1'b1) begin n_fail++; $display("FAIL stall_hold[%0d]: got rdy=%b locked=%b want 0010/1", i, in_ready, locked); end
      n_checks++; if (out_valid !== (i == 0)) begin n_fail++; $display("FAIL stall_out[%0d]: got v=%b src=%0d want v=%0d", i, out_valid, out_src, i == 0); end
      pedge();
    end
    in_valid = 4'b1010; in_data[1] = 32'hD1; in_last[1] = 1'b1;
    nedge();
    n_checks++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL stall_resume: got %b want 0010", in_ready); end
    pedge(); in_valid = 4'b1000;
    nedge();
    n_checks++; if (out_src !== 2'd1 || out_data !== 32'hD1 || out_last !== 1'b1) begin n_fail++; $display("FAIL stall_last: got src=%0d data=%h last=%b want 1/d1/1", out_src, out_data, out_last); end
    n_checks++; if (locked !== 1'b0 || in_ready !== 4'b1000) begin n_fail++; $display("FAIL stall_unlock: got locked=%b rdy=%b want 0/1000", locked, in_ready); end
    pedge(); in_valid = '0;
    nedge();
    n_checks++; if (out_valid !== 1'b1 || out_src !== 2'd3 || out_data !== 32'hE0) begin n_fail++; $display("FAIL stall_src3: got v=%b src=%0d data=%h want 1/3/e0", out_valid, out_src, out_data); end
    repeat (2) pedge();
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0; in_valid = 4'b0001; in_last[0] = 1'b1; in_data[0] = 32'hF0;
    nedge();
    n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_ready0: got %b want 0001", in_ready); end
    pedge(); in_data[0] = 32'hF1;
    nedge();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hF0) begin n_fail++; $display("FAIL bp_first: got v=%b data=%h want 1/f0", out_valid, out_data); end
    pedge(); in_data[0] = 32'hF2;
    for (int i = 0; i < 2; i++) begin
      nedge();
      n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_full[%0d]: got %b want 0000", i, in_ready); end
      n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hF0) begin n_fail++; $display("FAIL bp_stable[%0d]: got v=%b data=%h want 1/f0", i, out_valid, out_data); end
      pedge();
    end
    out_ready = 1'b1;
    nedge();
    n_checks++; if (out_data !== 32'hF0 || in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_drain0: got data=%h rdy=%b want f0/0000", out_data, in_ready); end
    pedge();
    nedge();
    n_checks++; if (out_data !== 32'hF1 || in_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_drain1: got data=%h rdy=%b want f1/0001", out_data, in_ready); end
    pedge(); in_valid = '0;
    nedge();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hF2) begin n_fail++; $display("FAIL bp_drain2: got v=%b data=%h want 1/f2", out_valid, out_data); end
    pedge();
    nedge();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    in_valid = 4'b0100; in_data[2] = 32'h60; in_last[2] = 1'b1;
    nedge();
    n_checks++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL rst_pre_grant: got %b want 0100", in_ready); end
    pedge(); in_data[2] = 32'h61; in_last[2] = 1'b0;
    nedge();
    pedge(); in_data[2] = 32'h62;
    nedge();
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL rst_pre_locked: got %b want 1", locked); end
    pedge(); in_data[2] = 32'h63;
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || locked !== 1'b0 || in_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_async: got v=%b locked=%b rdy=%b want 0/0/0000", out_valid, locked, in_ready); end
    in_valid = 4'b1100; in_last = 4'b1100; in_data[2] = 32'h72; in_data[3] = 32'h73;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    nedge();
    n_checks++; if (in_ready !== 4'b0100 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_post_grant: got rdy=%b v=%b want 0100/0", in_ready, out_valid); end
    pedge(); in_valid = '0;
    nedge();
    n_checks++; if (out_src !== 2'd2 || out_data !== 32'h72) begin n_fail++; $display("FAIL rst_post_beat: got src=%0d data=%h want 2/72", out_src, out_data); end
    repeat (2) pedge();
  endtask

  task automatic test_random();
    logic [N_REQ-1:0] pend, started, acc;
    int               left [N_REQ];
    int               seq [N_REQ];
    int               wait_pk [N_REQ];
    logic [34:0]      sb [$];
    int               open_src, idx;
    logic             stall_prev;
    logic [34:0]      prev_out;
    do_reset();
    pend = '0; started = '0; open_src = -1; stall_prev = 1'b0; prev_out = '0;
    for (int s = 0; s < N_REQ; s++) begin left[s] = 0; seq[s] = 0; wait_pk[s] = 0; end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      nedge();
      acc = in_valid & in_ready;
      n_checks++; if ($countones(in_ready) > 1) begin n_fail++; $display("FAIL rnd_onehot_ready @%0d: got %b want at most one bit", cyc, in_ready); end
      if (stall_prev) begin
        n_checks++;
        if (out_valid !== 1'b1 || {out_src, out_last, out_data} !== prev_out) begin n_fail++; $display("FAIL rnd_stable @%0d: got v=%b %h want 1 %h", cyc, out_valid, {out_src, out_last, out_data}, prev_out); end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (open_src >= 0 && int'(out_src) != open_src) begin n_fail++; $display("FAIL rnd_interleave @%0d: got src=%0d want src=%0d", cyc, out_src, open_src); end
        idx = -1;
        for (int j = 0; j < sb.size(); j++) begin
          if (sb[j][34:33] == out_src) begin idx = j; break; end
        end
        n_checks++;
        if (idx < 0) begin
          n_fail++; $display("FAIL rnd_spurious @%0d: got src=%0d data=%h want no beat", cyc, out_src, out_data);
        end else begin
          if (sb[idx][32:0] !== {out_last, out_data}) begin n_fail++; $display("FAIL rnd_order @%0d: got %h want %h", cyc, {out_last, out_data}, sb[idx][32:0]); end
          sb.delete(idx);
        end
        open_src = out_last ? -1 : int'(out_src);
      end
      stall_prev = out_valid && !out_ready;
      prev_out   = {out_src, out_last, out_data};
      for (int s = 0; s < N_REQ; s++) begin
        if (acc[s]) begin
          sb.push_back({2'(s), in_last[s], in_data[s]});
          if (!started[s]) begin
            n_checks++; if (wait_pk[s] > N_REQ - 1) begin n_fail++; $display("FAIL rnd_fair src%0d @%0d: got %0d packets waited want <= %0d", s, cyc, wait_pk[s], N_REQ - 1); end
            wait_pk[s] = 0;
          end
          if (in_last[s]) begin
            for (int t = 0; t < N_REQ; t++) begin
              if (t != s && pend[t] && !started[t]) wait_pk[t]++;
            end
          end
        end
      end
      @(posedge clock);
      #1;
      for (int s = 0; s < N_REQ; s++) begin
        if (acc[s]) begin
          seq[s]++; left[s]--; started[s] = 1'b1;
          if (left[s] == 0) begin pend[s] = 1'b0; started[s] = 1'b0; end
        end
        if (!pend[s] && cyc < 9940 && $urandom_range(2) == 0) begin
          pend[s] = 1'b1; left[s] = int'($urandom_range(3, 1)); wait_pk[s] = 0;
        end
        in_valid[s] = pend[s] && (!started[s] || cyc >= 9940 || $urandom_range(3) != 0);
        in_data[s]  = {8'(s), 24'(seq[s])};
        in_last[s]  = (left[s] == 1);
      end
      out_ready = (cyc >= 9940) || ($urandom_range(3) != 0);
    end
    n_checks++; if (sb.size() != 0 || pend != '0) begin n_fail++; $display("FAIL rnd_drain: got %0d beats outstanding, pend=%b want 0", sb.size(), pend); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_stall_lock();
    test_backpressure();
    test_reset_mid_packet();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
